// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-add multiplier with valid/ready handshakes
// Optional macro SEQ_MULT_SIGNED_EN enables two's complement operation selected by in_signed.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    counter;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    prod_next;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign;
  logic sign_next;
  logic a_neg;
  logic b_neg;

  // Operand conditioning: magnitudes and result sign; a zero operand forces a positive result.
  always_comb begin
    a_neg     = in_signed & in_a[WIDTH-1];
    b_neg     = in_signed & in_b[WIDTH-1];
    a_mag     = a_neg ? (~in_a + 1'b1) : in_a;
    b_mag     = b_neg ? (~in_b + 1'b1) : in_b;
    sign_next = (a_neg ^ b_neg) && (in_a != '0) && (in_b != '0);
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;

  // Operands always taken as unsigned magnitudes.
  always_comb begin
    a_mag = in_a;
    b_mag = in_b;
  end
`endif

  // One partial product step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_sum = acc;
    if (b_reg[0]) begin
      acc_sum = acc + (PW'(a_reg) << counter);
    end
  end

  // Final product as it will be registered on the BUSY->DONE edge.
  always_comb begin
    prod_next = acc_sum;
`ifdef SEQ_MULT_SIGNED_EN
    if (sign) begin
      prod_next = ~acc_sum + 1'b1;
    end
`endif
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      busy      <= 1'b0;
      counter   <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a_mag;
            b_reg    <= b_mag;
`ifdef SEQ_MULT_SIGNED_EN
            sign     <= sign_next;
`endif
            acc      <= '0;
            counter  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc     <= acc_sum;
          b_reg   <= b_reg >> 1;
          counter <= counter + 1'b1;
          // Fixed latency: no early exit when the remaining multiplier bits are zero.
          if (counter == LAST_STEP) begin
            out_p     <= prod_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Product and valid are held until the consumer takes them; new operands wait for IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - self-checking bench for seq_shift_add_mult (WIDTH=4)
module tb_seq_shift_add_mult;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction; the product is held for 'hold' cycles with out_ready low before it is taken.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [2*W-1:0] exp, input int hold);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    check("busy_after_accept", {30'd0, busy, in_ready}, 32'b10);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("product", 32'(out_p), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_a = 4'd1; in_b = 4'd1;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_product", 32'(out_p), 32'(exp));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consumed_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    int accepts[$];

    vecs.push_back('{4'd15, 4'd15, 1'b0, 8'hE1});
    vecs.push_back('{4'd0,  4'd9,  1'b0, 8'h00});
    vecs.push_back('{4'd7,  4'd0,  1'b0, 8'h00});
    vecs.push_back('{4'd1,  4'd1,  1'b0, 8'h01});
    vecs.push_back('{4'd3,  4'd5,  1'b0, 8'h0F});
    vecs.push_back('{4'hD,  4'd5,  1'b0, 8'h41});
    vecs.push_back('{4'd8,  4'd8,  1'b0, 8'h40});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{4'hD,  4'd5,  1'b1, 8'hF1});
    vecs.push_back('{4'h8,  4'h8,  1'b1, 8'h40});
    vecs.push_back('{4'h8,  4'd7,  1'b1, 8'hC8});
    vecs.push_back('{4'd0,  4'hF,  1'b1, 8'h00});
    vecs.push_back('{4'hF,  4'hF,  1'b1, 8'h01});
`else
    vecs.push_back('{4'hD,  4'd5,  1'b1, 8'h41});
    vecs.push_back('{4'hF,  4'hF,  1'b1, 8'hE1});
`endif

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_p", 32'(out_p), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, 0);
    end

    // Stalled consumer for 10 cycles with in_valid pulses that must be ignored.
    run_op(4'd6, 4'd7, 1'b0, 8'd42, 10);

    // Reset on the second BUSY cycle discards everything; previous out_p is 42, reset must clear it.
    @(negedge clk);
    in_a = 4'd9; in_b = 4'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midbusy_rst_out_p", 32'(out_p), 32'd0);
    check("midbusy_rst_flags", {29'd0, out_valid, in_ready, busy}, 32'b010);
    #1 rst = 1'b0;
    run_op(4'd3, 4'd5, 1'b0, 8'd15, 0);

    // Back-to-back: in_valid and out_ready held high; accepts must be spaced 6 cycles apart.
    @(negedge clk);
    in_a = 4'd2; in_b = 4'd3; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (in_ready) accepts.push_back(cyc);
      if (out_valid) check("b2b_product", 32'(out_p), 32'd6);
    end
    in_valid = 1'b0;
    check("b2b_accept_count", 32'(accepts.size()), 32'd5);
    for (int i = 1; i < accepts.size(); i++) begin
      check("b2b_spacing", 32'(accepts[i] - accepts[i-1]), 32'(W + 2));
    end
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    check("b2b_drained", {29'd0, out_valid, in_ready, busy}, 32'b010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
